// File: rtl/time_of_day_counter.sv
// ---------------------------------------------------------------------------
// time_of_day_counter
//
// Keeps 24-hour wall-clock time (HH:MM, packed BCD) driven by the one-minute
// tick from the minute timer. It also holds an alarm time and raises a ring
// request when a tick-driven time advance lands on the alarm time. It is the
// sole owner of the time and alarm registers.
//
// Parameters:
//   INIT_TIME   packed BCD time loaded on reset
//   INIT_ALARM  packed BCD alarm loaded on reset
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high (overrides clk_ena)
//   clk_ena     global enable; when low every register holds
//   min_tick    one-cycle pulse per elapsed minute
//   mode        00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RUN
//   inc_min     one-cycle pulse: +1 minute on the register chosen by mode
//   inc_hr      one-cycle pulse: +1 hour on the register chosen by mode
//   alarm_arm   level, 1 = alarm enabled
//   alarm_clr   one-cycle pulse, silences a ringing alarm
//   time_bcd    {hr_tens, hr_ones, min_tens, min_ones}
//   alarm_bcd   alarm time, same packing
//   hour_tc     one-cycle pulse on a tick-driven 23:59 -> 00:00 wrap
//   alarm_ring  level ring request
// ---------------------------------------------------------------------------
module time_of_day_counter #(
  parameter logic [15:0] INIT_TIME  = 16'h1200,
  parameter logic [15:0] INIT_ALARM = 16'h0700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_ena,
  input  logic        min_tick,
  input  logic [1:0]  mode,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic        alarm_arm,
  input  logic        alarm_clr,
  output logic [15:0] time_bcd,
  output logic [15:0] alarm_bcd,
  output logic        hour_tc,
  output logic        alarm_ring
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2
  } alarm_state_t;

  // Minutes byte +1, 59 wraps to 00 (caller decides on hour carry).
  function automatic logic [7:0] min_plus1(input logic [7:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[7:4] == 4'd5) return 8'h00;
      else                return {m[7:4] + 4'd1, 4'd0};
    end
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  // Hours byte +1, 23 wraps to 00.
  function automatic logic [7:0] hr_plus1(input logic [7:0] h);
    if (h == 8'h23) return 8'h00;
    if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  logic [15:0]  time_reg,  time_next;
  logic [15:0]  alarm_reg, alarm_next;
  logic         hour_tc_reg;
  logic         ring_reg;
  alarm_state_t state_reg;

  logic mode_run, mode_set_time, mode_set_alarm;
  logic tick_adv;     // a tick that actually advances time this edge
  logic tick_match;   // tick-driven advance lands on the alarm time
  logic hour_wrap;    // tick-driven 23:59 -> 00:00

  // 11 decodes as RUN, so RUN is "both mode bits equal".
  assign mode_run       = (mode[1] == mode[0]);
  assign mode_set_time  = (mode == 2'b01);
  assign mode_set_alarm = (mode == 2'b10);

  // In SET_TIME the tick is dropped entirely, not deferred.
  assign tick_adv = clk_ena && min_tick && (mode_run || mode_set_alarm);

  always_comb begin
    time_next  = time_reg;
    alarm_next = alarm_reg;

    if (tick_adv) begin
      time_next[7:0] = min_plus1(time_reg[7:0]);
      if (time_reg[7:0] == 8'h59)
        time_next[15:8] = hr_plus1(time_reg[15:8]);
    end else if (clk_ena && mode_set_time) begin
      // Set increments never carry between minutes and hours.
      if (inc_min) time_next[7:0]  = min_plus1(time_reg[7:0]);
      if (inc_hr)  time_next[15:8] = hr_plus1(time_reg[15:8]);
    end

    if (clk_ena && mode_set_alarm) begin
      if (inc_min) alarm_next[7:0]  = min_plus1(alarm_reg[7:0]);
      if (inc_hr)  alarm_next[15:8] = hr_plus1(alarm_reg[15:8]);
    end
  end

  // Compared against the alarm value currently held, so only a tick can ring.
  assign tick_match = tick_adv && (time_next == alarm_reg);
  assign hour_wrap  = tick_adv && (time_reg == 16'h2359);

  always_ff @(posedge clk) begin
    if (rst) begin
      time_reg    <= INIT_TIME;
      alarm_reg   <= INIT_ALARM;
      hour_tc_reg <= 1'b0;
      ring_reg    <= 1'b0;
      state_reg   <= ST_IDLE;
    end else if (clk_ena) begin
      time_reg    <= time_next;
      alarm_reg   <= alarm_next;
      hour_tc_reg <= hour_wrap;

      case (state_reg)
        ST_IDLE: begin
          // Arming takes the whole edge; a coincident tick cannot ring.
          if (alarm_arm) begin
            state_reg <= ST_ARMED;
          end
          ring_reg <= 1'b0;
        end
        ST_ARMED: begin
          if (!alarm_arm) begin
            state_reg <= ST_IDLE;
            ring_reg  <= 1'b0;
          end else if (tick_match) begin
            state_reg <= ST_RINGING;
            ring_reg  <= 1'b1;
          end else begin
            ring_reg  <= 1'b0;
          end
        end
        ST_RINGING: begin
          // Disarm beats clear; a fresh match beats clear.
          if (!alarm_arm) begin
            state_reg <= ST_IDLE;
            ring_reg  <= 1'b0;
          end else if (tick_match) begin
            state_reg <= ST_RINGING;
            ring_reg  <= 1'b1;
          end else if (alarm_clr) begin
            state_reg <= ST_ARMED;
            ring_reg  <= 1'b0;
          end else begin
            ring_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ring_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign time_bcd   = time_reg;
  assign alarm_bcd  = alarm_reg;
  assign hour_tc    = hour_tc_reg;
  assign alarm_ring = ring_reg;

endmodule

// File: tb/tb_time_of_day_counter.sv
// ---------------------------------------------------------------------------
// Testbench for time_of_day_counter: a table of single-cycle vectors with
// hand-computed expectations, followed by hand-written multi-cycle sequences
// for carries, wraps and the alarm state machine.
// ---------------------------------------------------------------------------
module tb_time_of_day_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_ena;
  logic        min_tick;
  logic [1:0]  mode;
  logic        inc_min;
  logic        inc_hr;
  logic        alarm_arm;
  logic        alarm_clr;
  logic [15:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic        hour_tc;
  logic        alarm_ring;

  int n_checks = 0;
  int n_fail   = 0;
  logic arm_lvl = 1'b0;

  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_SETT = 2'b01;
  localparam logic [1:0] M_SETA = 2'b10;
  localparam logic [1:0] M_RUN3 = 2'b11;

  time_of_day_counter #(
    .INIT_TIME (16'h1200),
    .INIT_ALARM(16'h0700)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_ena   (clk_ena),
    .min_tick  (min_tick),
    .mode      (mode),
    .inc_min   (inc_min),
    .inc_hr    (inc_hr),
    .alarm_arm (alarm_arm),
    .alarm_clr (alarm_clr),
    .time_bcd  (time_bcd),
    .alarm_bcd (alarm_bcd),
    .hour_tc   (hour_tc),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ena;
    logic        tick;
    logic [1:0]  mode;
    logic        imin;
    logic        ihr;
    logic        arm;
    logic        clr;
    logic [15:0] exp_time;
    logic [15:0] exp_alarm;
    logic        exp_tc;
    logic        exp_ring;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [15:0] to_bcd(input int mins);
    int h, m;
    h = (mins / 60) % 24;
    m = mins % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic e, input logic t, input logic [1:0] m,
                      input logic im, input logic ih, input logic c);
    rst = r; clk_ena = e; min_tick = t; mode = m;
    inc_min = im; inc_hr = ih; alarm_arm = arm_lvl; alarm_clr = c;
    @(posedge clk);
    #1;
    min_tick = 1'b0; inc_min = 1'b0; inc_hr = 1'b0; alarm_clr = 1'b0; rst = 1'b0;
  endtask

  // Repeated set/run pulses; hour_tc and alarm_ring must stay low throughout.
  task automatic pulses(input int n, input logic [1:0] m, input logic t,
                        input logic im, input logic ih, input string name);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, t, m, im, ih, 1'b0);
      chk({name, "_tc"}, {15'd0, hour_tc}, 16'd0);
      chk({name, "_ring"}, {15'd0, alarm_ring}, 16'd0);
    end
  endtask

  initial begin
    rst = 1'b1; clk_ena = 1'b0; min_tick = 1'b0; mode = M_RUN;
    inc_min = 1'b0; inc_hr = 1'b0; alarm_arm = 1'b0; alarm_clr = 1'b0;

    //            rst  ena  tick mode    imin ihr  arm  clr  time      alarm     tc   ring
    vecs[0]  = '{1'b1,1'b0,1'b0,M_RUN ,1'b0,1'b0,1'b0,1'b0,16'h1200,16'h0700,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,M_RUN ,1'b0,1'b0,1'b0,1'b0,16'h1201,16'h0700,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,M_RUN ,1'b0,1'b0,1'b0,1'b0,16'h1201,16'h0700,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,M_SETT,1'b0,1'b0,1'b0,1'b0,16'h1201,16'h0700,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,M_SETT,1'b1,1'b0,1'b0,1'b0,16'h1202,16'h0700,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,M_SETT,1'b0,1'b1,1'b0,1'b0,16'h1302,16'h0700,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,M_SETT,1'b1,1'b1,1'b0,1'b0,16'h1403,16'h0700,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,M_RUN ,1'b1,1'b1,1'b0,1'b0,16'h1403,16'h0700,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b1,M_RUN3,1'b0,1'b0,1'b0,1'b0,16'h1404,16'h0700,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,1'b0,M_SETA,1'b1,1'b0,1'b0,1'b0,16'h1404,16'h0701,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b1,M_SETA,1'b0,1'b1,1'b0,1'b0,16'h1405,16'h0801,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,M_SETA,1'b1,1'b0,1'b0,1'b0,16'h1405,16'h0801,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b0,M_RUN ,1'b0,1'b0,1'b0,1'b0,16'h1200,16'h0700,1'b0,1'b0};

    for (int v = 0; v < 13; v++) begin
      arm_lvl = vecs[v].arm;
      step(vecs[v].rst, vecs[v].ena, vecs[v].tick, vecs[v].mode,
           vecs[v].imin, vecs[v].ihr, vecs[v].clr);
      chk($sformatf("vec%0d_time", v),  time_bcd,  vecs[v].exp_time);
      chk($sformatf("vec%0d_alarm", v), alarm_bcd, vecs[v].exp_alarm);
      chk($sformatf("vec%0d_tc", v),    {15'd0, hour_tc},    {15'd0, vecs[v].exp_tc});
      chk($sformatf("vec%0d_ring", v),  {15'd0, alarm_ring}, {15'd0, vecs[v].exp_ring});
    end
    arm_lvl = 1'b0;

    // 61 ticks in RUN from 12:00, minute-by-minute against a decimal model.
    for (int i = 1; i <= 61; i++) begin
      step(1'b0, 1'b1, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
      chk($sformatf("run61_t%0d", i), time_bcd, to_bcd(720 + i));
      chk("run61_tc", {15'd0, hour_tc}, 16'd0);
    end
    chk("run61_final", time_bcd, 16'h1301);

    // Back to 12:00, wrap hours to 00:00, then build 23:59 by set pulses.
    step(1'b1, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    pulses(12, M_SETT, 1'b0, 1'b0, 1'b1, "hr_wrap");
    chk("set_0000", time_bcd, 16'h0000);
    pulses(23, M_SETT, 1'b0, 1'b0, 1'b1, "set_hr");
    chk("set_2300", time_bcd, 16'h2300);
    pulses(59, M_SETT, 1'b0, 1'b1, 1'b0, "set_min");
    chk("set_2359", time_bcd, 16'h2359);
    step(1'b0, 1'b1, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("wrap_time", time_bcd, 16'h0000);
    chk("wrap_tc_hi", {15'd0, hour_tc}, 16'd1);
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("wrap_tc_lo", {15'd0, hour_tc}, 16'd0);
    chk("wrap_hold", time_bcd, 16'h0000);

    // Set-mode minute wrap does not carry into hours.
    pulses(12, M_SETT, 1'b0, 1'b0, 1'b1, "to12");
    pulses(59, M_SETT, 1'b0, 1'b1, 1'b0, "to1259");
    chk("set_1259", time_bcd, 16'h1259);
    pulses(1, M_SETT, 1'b0, 1'b1, 1'b0, "min_wrap");
    chk("set_min_nocarry", time_bcd, 16'h1200);
    pulses(12, M_SETT, 1'b0, 1'b0, 1'b1, "hr12");
    chk("set_hr12_wrap", time_bcd, 16'h0000);

    // Alarm ring at 07:00 from 06:59.
    pulses(6, M_SETT, 1'b0, 1'b0, 1'b1, "to06");
    pulses(59, M_SETT, 1'b0, 1'b1, 1'b0, "to0659");
    chk("al_0659", time_bcd, 16'h0659);
    arm_lvl = 1'b1;
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("al_armed_quiet", {15'd0, alarm_ring}, 16'd0);
    step(1'b0, 1'b1, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("al_ring_time", time_bcd, 16'h0700);
    chk("al_ring_rise", {15'd0, alarm_ring}, 16'd1);
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("al_ring_hold", {15'd0, alarm_ring}, 16'd1);
    step(1'b0, 1'b1, 1'b0, M_SETT, 1'b0, 1'b0, 1'b0);
    chk("al_ring_settime", {15'd0, alarm_ring}, 16'd1);
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b1);
    chk("al_clr", {15'd0, alarm_ring}, 16'd0);
    // Still armed: a second tick onto 07:00 rings again.
    pulses(23, M_SETT, 1'b0, 1'b0, 1'b1, "back06");
    pulses(59, M_SETT, 1'b0, 1'b1, 1'b0, "back0659");
    step(1'b0, 1'b1, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("al_rearm_ring", {15'd0, alarm_ring}, 16'd1);
    // Disarm wins over clear.
    arm_lvl = 1'b0;
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b1);
    chk("al_disarm", {15'd0, alarm_ring}, 16'd0);

    // Armed: matches built from set pulses never ring.
    arm_lvl = 1'b1;
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    pulses(23, M_SETT, 1'b0, 1'b0, 1'b1, "sm06");
    pulses(60, M_SETT, 1'b0, 1'b1, 1'b0, "sm_to0600");
    pulses(1, M_SETT, 1'b0, 1'b0, 1'b1, "sm_to0700");
    chk("setmatch_time", time_bcd, 16'h0700);
    pulses(23, M_SETA, 1'b0, 1'b0, 1'b1, "sa06");
    chk("seta_0600", alarm_bcd, 16'h0600);
    pulses(1, M_SETA, 1'b0, 1'b0, 1'b1, "sa07");
    chk("seta_0700", alarm_bcd, 16'h0700);

    // Arming on the same edge as a matching tick does not ring.
    arm_lvl = 1'b0;
    step(1'b0, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    pulses(23, M_SETT, 1'b0, 1'b0, 1'b1, "ar06");
    pulses(59, M_SETT, 1'b0, 1'b1, 1'b0, "ar0659");
    arm_lvl = 1'b1;
    step(1'b0, 1'b1, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("arm_tick_time", time_bcd, 16'h0700);
    chk("arm_tick_noring", {15'd0, alarm_ring}, 16'd0);

    // Ring via a tick in SET_ALARM, then reset mid-ring.
    pulses(1, M_SETA, 1'b0, 1'b1, 1'b0, "sa0701");
    chk("seta_0701", alarm_bcd, 16'h0701);
    step(1'b0, 1'b1, 1'b1, M_SETA, 1'b0, 1'b0, 1'b0);
    chk("seta_tick_time", time_bcd, 16'h0701);
    chk("seta_tick_ring", {15'd0, alarm_ring}, 16'd1);
    step(1'b1, 1'b1, 1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("rst_ring", {15'd0, alarm_ring}, 16'd0);
    chk("rst_time", time_bcd, 16'h1200);
    chk("rst_alarm", alarm_bcd, 16'h0700);
    step(1'b0, 1'b0, 1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    chk("ena_low_hold", time_bcd, 16'h1200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
